pc_seq: RTL and testbench

Parametrised program-counter sequencer for the soft processor's fetch stage. It holds the current instruction address and selects the next one each cycle from five sources: increment, relative branch, absolute jump, call, and return. Calls and returns use an internal return-address stack (RAS). It sits between the decode/control logic, which supplies the redirect requests, and instruction memory, which consumes `pc`.

---
 rtl/pc_seq_pkg.sv | 19 +
 rtl/pc_seq_ras.sv | 87 ++++++++
 rtl/pc_seq.sv | 134 +++++++++++++
 tb/tb_pc_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and default parameters for the fetch-stage
// program-counter sequencer (pc_seq) and its return-address stack.
//   next_sel_t    : next-PC source selector
//   PC_WIDTH_DEF  : default address width
//   RAS_DEPTH_DEF : default return-address stack depth
package pc_seq_pkg;

    localparam int unsigned PC_WIDTH_DEF  = 32;
    localparam int unsigned RAS_DEPTH_DEF = 4;

    typedef enum logic [2:0] {
        SEL_INC,
        SEL_BRANCH,
        SEL_JUMP,
        SEL_CALL,
        SEL_RET
    } next_sel_t;

endpackage

// File: rtl/pc_seq_ras.sv
// ras_stack: circular LIFO holding return addresses for pc_seq.
// Built only when PC_SEQ_RAS_EN is defined.
//   clk, rst : clock, asynchronous active-high reset (clears pointer/count)
//   push     : write din on top; when full the oldest entry is overwritten
//   pop      : discard top; ignored when empty
//   din      : address to push
//   top      : most recently pushed live entry (don't-care when empty)
//   empty    : count == 0 (registered state)
//   full     : count == DEPTH (registered state)
//   ovf, unf : this cycle's push/pop overflows/underflows
`ifdef PC_SEQ_RAS_EN
module ras_stack
    import pc_seq_pkg::*;
#(
    parameter int unsigned WIDTH = PC_WIDTH_DEF,
    parameter int unsigned DEPTH = RAS_DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             wr_en;

    // ptr_q is the next write slot; the top lives one below it. Because
    // DEPTH is a power of two the pointer wraps naturally, which is what
    // makes an overflowing push replace the oldest entry.
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign top   = mem_q[ptr_q - AW'(1)];

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        wr_en = 1'b0;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (pop) begin
            if (empty) begin
                unf = 1'b1;
            end else begin
                ptr_d = ptr_q - AW'(1);
                cnt_d = cnt_q - CW'(1);
            end
        end else if (push) begin
            wr_en = 1'b1;
            ptr_d = ptr_q + AW'(1);
            if (full) begin
                ovf = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry contents need no reset; only pointer and count are architectural.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[ptr_q] <= din;
        end
    end

endmodule
`endif

// File: rtl/pc_seq.sv
// pc_seq: fetch-stage program-counter sequencer.
// Selects the next PC each cycle: ret > call > jump > branch > increment.
// Configuration macro: PC_SEQ_RAS_EN builds the return-address stack;
// without it call acts as jump, ret acts as increment, and the RAS status
// outputs are tied off (empty=1, full=0, err=0).
//   clk, rst   : clock, asynchronous active-high reset
//   stall      : hold all state, ignore redirects
//   branch_en  : pc <= pc + branch_off (two's complement, wraps)
//   branch_off : signed branch offset
//   jump_en    : pc <= target
//   call_en    : push pc+1, pc <= target
//   ret_en     : pc <= RAS top and pop (pc+1 and error if empty)
//   target     : absolute jump/call address
//   pc         : current instruction address (registered)
//   ras_empty, ras_full : RAS occupancy (registered)
//   ras_err    : sticky overflow/underflow flag, cleared only by rst
module pc_seq
    import pc_seq_pkg::*;
#(
    parameter int unsigned      WIDTH     = PC_WIDTH_DEF,
    parameter int unsigned      RAS_DEPTH = RAS_DEPTH_DEF,
    parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_en,
    input  logic [WIDTH-1:0] branch_off,
    input  logic             jump_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_br;
    next_sel_t        sel;

    assign pc_inc = pc_q + WIDTH'(1);
    assign pc_br  = pc_q + branch_off;
    assign pc     = pc_q;

`ifdef PC_SEQ_RAS_EN
    logic [WIDTH-1:0] ras_top;
    logic             ras_push, ras_pop;
    logic             ras_ovf, ras_unf;
    logic             err_q, err_d;

    always_comb begin
        if (ret_en)         sel = SEL_RET;
        else if (call_en)   sel = SEL_CALL;
        else if (jump_en)   sel = SEL_JUMP;
        else if (branch_en) sel = SEL_BRANCH;
        else                sel = SEL_INC;
    end

    assign ras_push = !stall && (sel == SEL_CALL);
    assign ras_pop  = !stall && (sel == SEL_RET);

    ras_stack #(
        .WIDTH (WIDTH),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_inc),
        .top   (ras_top),
        .empty (ras_empty),
        .full  (ras_full),
        .ovf   (ras_ovf),
        .unf   (ras_unf)
    );

    always_comb begin
        err_d = err_q | ras_ovf | ras_unf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ras_err = err_q;
`else
    logic ret_unused;

    // Without a stack, call degenerates to jump and ret has no effect.
    always_comb begin
        if (call_en || jump_en) sel = SEL_JUMP;
        else if (branch_en)     sel = SEL_BRANCH;
        else                    sel = SEL_INC;
    end

    assign ret_unused = ret_en;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
    assign ras_err    = 1'b0;
`endif

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            case (sel)
                SEL_BRANCH: pc_d = pc_br;
                SEL_JUMP:   pc_d = target;
`ifdef PC_SEQ_RAS_EN
                SEL_CALL:   pc_d = target;
                // Underflowing return falls through to the next sequential address.
                SEL_RET:    pc_d = ras_empty ? pc_inc : ras_top;
`endif
                default:    pc_d = pc_inc;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_pc_seq.sv
// tb_pc_seq: directed scoreboard bench for pc_seq (RESET_PC = 0x10).
// Expected values depend on PC_SEQ_RAS_EN; R(a,b) picks a when the
// stack is built and b otherwise.
`ifdef PC_SEQ_RAS_EN
`define R(a, b) (a)
`else
`define R(a, b) (b)
`endif

module tb_pc_seq;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_en;
    logic [31:0] branch_off;
    logic        jump_en;
    logic        call_en;
    logic        ret_en;
    logic [31:0] target;
    logic [31:0] pc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_err;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic        e;
        logic        f;
        logic        r;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;
    int   n_chk;
    int   n_fail;

    pc_seq #(
        .WIDTH     (32),
        .RAS_DEPTH (4),
        .RESET_PC  (32'h10)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .branch_en  (branch_en),
        .branch_off (branch_off),
        .jump_en    (jump_en),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .target     (target),
        .pc         (pc),
        .ras_empty  (ras_empty),
        .ras_full   (ras_full),
        .ras_err    (ras_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input logic [31:0] e_pc,
                           input logic e_e, input logic e_f, input logic e_r);
        chk({nm, ".pc"}, pc, e_pc);
        chk({nm, ".empty"}, {31'b0, ras_empty}, {31'b0, e_e});
        chk({nm, ".full"}, {31'b0, ras_full}, {31'b0, e_f});
        chk({nm, ".err"}, {31'b0, ras_err}, {31'b0, e_r});
    endtask

    // Applies one cycle of inputs at the falling edge and records the state
    // expected after the following rising edge.
    task automatic drive(input string nm, input logic st, input logic br,
                         input logic jp, input logic cl, input logic rt,
                         input logic [31:0] off, input logic [31:0] tgt,
                         input logic [31:0] e_pc, input logic e_e,
                         input logic e_f, input logic e_r);
        stall      = st;
        branch_en  = br;
        jump_en    = jp;
        call_en    = cl;
        ret_en     = rt;
        branch_off = off;
        target     = tgt;
        exp_q.push_back('{nm, e_pc, e_e, e_f, e_r});
        @(negedge clk);
    endtask

    // Monitor: compares every recorded expectation just after its edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                mon_x = exp_q.pop_front();
                chk_all(mon_x.name, mon_x.pc, mon_x.e, mon_x.f, mon_x.r);
            end
        end
    end

    initial begin
        int budget;
        clk        = 1'b0;
        rst        = 1'b0;
        stall      = 1'b0;
        branch_en  = 1'b0;
        branch_off = '0;
        jump_en    = 1'b0;
        call_en    = 1'b0;
        ret_en     = 1'b0;
        target     = '0;
        n_chk      = 0;
        n_fail     = 0;

        // Asynchronous reset between edges
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all("reset", 32'h10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        //     name        st br jp cl rt  off           tgt           pc                     empty      full       err
        drive("inc1",      0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h11,                1,         0,         0);
        drive("inc2",      0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h12,                1,         0,         0);
        drive("inc3",      0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h13,                1,         0,         0);
        drive("jmp20",     0, 0, 1, 0, 0, 32'h0,        32'h20,       32'h20,                1,         0,         0);
        drive("br_neg",    0, 1, 0, 0, 0, 32'hFFFFFFFC, 32'h0,        32'h1C,                1,         0,         0);
        drive("br_pos",    0, 1, 0, 0, 0, 32'h5,        32'h0,        32'h21,                1,         0,         0);

        drive("jmp100",    0, 0, 1, 0, 0, 32'h0,        32'h100,      32'h100,               1,         0,         0);
        drive("call200",   0, 0, 0, 1, 0, 32'h0,        32'h200,      32'h200,               `R(0, 1),  0,         0);
        drive("call300",   0, 0, 0, 1, 0, 32'h0,        32'h300,      32'h300,               `R(0, 1),  0,         0);
        drive("ret_a",     0, 0, 0, 0, 1, 32'h0,        32'h0,        `R(32'h201, 32'h301),  `R(0, 1),  0,         0);
        drive("ret_b",     0, 0, 0, 0, 1, 32'h0,        32'h0,        `R(32'h101, 32'h302),  1,         0,         0);

        drive("jmp0",      0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h0,                 1,         0,         0);
        drive("call_1",    0, 0, 0, 1, 0, 32'h0,        32'h1,        32'h1,                 `R(0, 1),  0,         0);
        drive("call_2",    0, 0, 0, 1, 0, 32'h0,        32'h2,        32'h2,                 `R(0, 1),  0,         0);
        drive("call_3",    0, 0, 0, 1, 0, 32'h0,        32'h3,        32'h3,                 `R(0, 1),  0,         0);
        drive("call_4",    0, 0, 0, 1, 0, 32'h0,        32'h4,        32'h4,                 `R(0, 1),  `R(1, 0),  0);
        drive("call_ovf",  0, 0, 0, 1, 0, 32'h0,        32'h5,        32'h5,                 `R(0, 1),  `R(1, 0),  `R(1, 0));
        drive("ret_5",     0, 0, 0, 0, 1, 32'h0,        32'h0,        `R(32'h5, 32'h6),      `R(0, 1),  0,         `R(1, 0));
        drive("ret_4",     0, 0, 0, 0, 1, 32'h0,        32'h0,        `R(32'h4, 32'h7),      `R(0, 1),  0,         `R(1, 0));
        drive("ret_3",     0, 0, 0, 0, 1, 32'h0,        32'h0,        `R(32'h3, 32'h8),      `R(0, 1),  0,         `R(1, 0));
        drive("ret_2",     0, 0, 0, 0, 1, 32'h0,        32'h0,        `R(32'h2, 32'h9),      1,         0,         `R(1, 0));
        drive("ret_unf",   0, 0, 0, 0, 1, 32'h0,        32'h0,        `R(32'h3, 32'hA),      1,         0,         `R(1, 0));

        drive("call40",    0, 0, 0, 1, 0, 32'h0,        32'h40,       32'h40,                `R(0, 1),  0,         `R(1, 0));
        drive("prio",      0, 1, 0, 1, 1, 32'h10,       32'h80,       `R(32'h4, 32'h80),     1,         0,         `R(1, 0));
        drive("stall_jmp", 1, 0, 1, 0, 0, 32'h0,        32'h500,      `R(32'h4, 32'h80),     1,         0,         `R(1, 0));
        drive("stall_cl",  1, 0, 0, 1, 0, 32'h0,        32'h500,      `R(32'h4, 32'h80),     1,         0,         `R(1, 0));
        drive("unstall",   0, 0, 0, 0, 0, 32'h0,        32'h0,        `R(32'h5, 32'h81),     1,         0,         `R(1, 0));

        drive("jmp_ff_a",  0, 0, 1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF,          1,         0,         `R(1, 0));
        drive("wrap_inc",  0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,                 1,         0,         `R(1, 0));
        drive("jmp_ff_b",  0, 0, 1, 0, 0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFF,          1,         0,         `R(1, 0));
        drive("wrap_br",   0, 1, 0, 0, 0, 32'h1,        32'h0,        32'h0,                 1,         0,         `R(1, 0));

        // Idle inputs, then drain the scoreboard with a bounded wait
        drive("idle",      0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h1,                 1,         0,         `R(1, 0));
        budget = 0;
        while (exp_q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        n_chk++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        // Reset clears the sticky error and the stack
        #2 rst = 1'b1;
        #1 chk_all("reset2", 32'h10, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`undef R
